buton_clasificator: RTL and testbench



---
 rtl/buton_clasificator.sv | 196 +++++++++++++++++++
 tb/tb_buton_clasificator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/buton_clasificator.sv
// rtl/buton_clasificator.sv - N-channel push-button classifier: short, long (with auto-repeat) and double presses
// Each channel: two-flop synchroniser, debouncer, classification FSM; outputs are registered one-cycle pulses.
module buton_clasificator #(
    parameter int N_CH         = 3,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int LONG_CYC     = 16,
    parameter int DOUBLE_GAP   = 10,
    parameter int REPEAT_CYC   = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] b,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] scurt,
    output logic [N_CH-1:0] lung,
    output logic [N_CH-1:0] dublu,
    output logic [N_CH-1:0] busy
);
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESSED      = 3'd1;
    localparam logic [2:0] ST_LONG_HELD    = 3'd2;
    localparam logic [2:0] ST_WAIT_SECOND  = 3'd3;
    localparam logic [2:0] ST_SECOND_PRESS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DOUBLE_GAP);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [N_CH-1:0]  s1_q, s1_d, s2_q, s2_d;
    logic [N_CH-1:0]  db_q, db_d, rel_q, rel_d;
    logic [N_CH-1:0]  scurt_q, scurt_d, lung_q, lung_d, dublu_q, dublu_d, busy_q, busy_d;
    logic [1:0]       vld_q, vld_d;
    logic [2:0]       st_q [N_CH];
    logic [2:0]       st_d [N_CH];
    logic [CNT_W-1:0] dc_q [N_CH];
    logic [CNT_W-1:0] dc_d [N_CH];
    logic [CNT_W-1:0] h_q  [N_CH];
    logic [CNT_W-1:0] h_d  [N_CH];
    logic [CNT_W-1:0] g_q  [N_CH];
    logic [CNT_W-1:0] g_d  [N_CH];
    logic [CNT_W-1:0] r_q  [N_CH];
    logic [CNT_W-1:0] r_d  [N_CH];

    always_comb begin
        s1_d    = b;
        s2_d    = s1_q;
        // s2 holds a real button sample only from the second edge after reset
        vld_d   = {vld_q[0], 1'b1};
        db_d    = db_q;
        rel_d   = rel_q;
        scurt_d = '0;
        lung_d  = '0;
        dublu_d = '0;
        busy_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i] = st_q[i];
            dc_d[i] = '0;
            h_d[i]  = h_q[i];
            g_d[i]  = g_q[i];
            r_d[i]  = r_q[i];

            if (s2_q[i] != db_q[i]) begin
                if (sat_inc(dc_q[i]) >= DB_LIM) begin
                    db_d[i] = s2_q[i];
                end else begin
                    dc_d[i] = sat_inc(dc_q[i]);
                end
            end

            case (st_q[i])
                ST_IDLE: begin
                    if (db_q[i] && rel_q[i]) begin
                        st_d[i] = ST_PRESSED;
                        h_d[i]  = CNT_ONE;
                    end
                    // arm only after a genuinely released button has been observed
                    rel_d[i] = rel_q[i] | (vld_q[1] & ~db_q[i] & ~s2_q[i]);
                end
                ST_PRESSED: begin
                    if (db_q[i]) begin
                        h_d[i] = sat_inc(h_q[i]);
                        if (sat_inc(h_q[i]) >= LONG_LIM) begin
                            lung_d[i] = 1'b1;
                            r_d[i]    = '0;
                            st_d[i]   = ST_LONG_HELD;
                        end
                    end else if (DOUBLE_GAP == 0) begin
                        scurt_d[i] = 1'b1;
                        st_d[i]    = ST_IDLE;
                    end else begin
                        g_d[i]  = CNT_ONE;
                        st_d[i] = ST_WAIT_SECOND;
                    end
                end
                ST_LONG_HELD: begin
                    if (!db_q[i]) begin
                        st_d[i] = ST_IDLE;
                    end else begin
                        h_d[i] = sat_inc(h_q[i]);
                        if (REPEAT_CYC > 0) begin
                            if (sat_inc(r_q[i]) >= REP_LIM) begin
                                lung_d[i] = 1'b1;
                                r_d[i]    = '0;
                            end else begin
                                r_d[i] = sat_inc(r_q[i]);
                            end
                        end
                    end
                end
                ST_WAIT_SECOND: begin
                    if (db_q[i]) begin
                        st_d[i] = ST_SECOND_PRESS;
                    end else begin
                        g_d[i] = sat_inc(g_q[i]);
                        if (sat_inc(g_q[i]) >= GAP_LIM) begin
                            scurt_d[i] = 1'b1;
                            st_d[i]    = ST_IDLE;
                        end
                    end
                end
                ST_SECOND_PRESS: begin
                    if (!db_q[i]) begin
                        dublu_d[i] = 1'b1;
                        st_d[i]    = ST_IDLE;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase

            if (!ch_en[i]) begin
                st_d[i]    = ST_IDLE;
                db_d[i]    = 1'b0;
                rel_d[i]   = 1'b0;
                dc_d[i]    = '0;
                h_d[i]     = '0;
                g_d[i]     = '0;
                r_d[i]     = '0;
                scurt_d[i] = 1'b0;
                lung_d[i]  = 1'b0;
                dublu_d[i] = 1'b0;
            end
            busy_d[i] = (st_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            rel_q   <= '0;
            vld_q   <= '0;
            scurt_q <= '0;
            lung_q  <= '0;
            dublu_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                st_q[i] <= ST_IDLE;
                dc_q[i] <= '0;
                h_q[i]  <= '0;
                g_q[i]  <= '0;
                r_q[i]  <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            rel_q   <= rel_d;
            vld_q   <= vld_d;
            scurt_q <= scurt_d;
            lung_q  <= lung_d;
            dublu_q <= dublu_d;
            busy_q  <= busy_d;
            for (int i = 0; i < N_CH; i++) begin
                st_q[i] <= st_d[i];
                dc_q[i] <= dc_d[i];
                h_q[i]  <= h_d[i];
                g_q[i]  <= g_d[i];
                r_q[i]  <= r_d[i];
            end
        end
    end

    assign scurt = scurt_q;
    assign lung  = lung_q;
    assign dublu = dublu_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_buton_clasificator.sv
// tb/tb_buton_clasificator.sv - randomized press/release/enable/reset stimulus against a timestamp-based press model
// Instance 0 exercises double/repeat, instance 1 exercises short-without-gap and 4-bit counter saturation.
module tb_buton_clasificator;
    localparam int NC  = 3;
    localparam int DB0 = 4, L0 = 16, G0 = 10, R0 = 8;
    localparam int DB1 = 2, L1 = 15, G1 = 0,  R1 = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic [NC-1:0] b, ch_en;
    logic [NC-1:0] scurt0, lung0, dublu0, busy0;
    logic [NC-1:0] scurt1, lung1, dublu1, busy1;

    int n_vec = 0;
    int n_err = 0;
    int t = 0;
    int since_rst = 0;

    int m_s1 [2][NC], m_s2 [2][NC], m_db [2][NC], m_run [2][NC], m_arm [2][NC];
    int m_rise [2][NC], m_fall [2][NC], m_sec [2][NC];
    int m_ex_s [2][NC], m_ex_l [2][NC], m_ex_d [2][NC], m_busy [2][NC];

    int lv [NC], run_left [NC], en_left [NC];

    always #5 clock = ~clock;

    buton_clasificator #(.N_CH(NC), .CNT_W(8), .DEBOUNCE_CYC(DB0), .LONG_CYC(L0),
                         .DOUBLE_GAP(G0), .REPEAT_CYC(R0)) u_dut0 (
        .clock(clock), .reset(reset), .b(b), .ch_en(ch_en),
        .scurt(scurt0), .lung(lung0), .dublu(dublu0), .busy(busy0));

    buton_clasificator #(.N_CH(NC), .CNT_W(4), .DEBOUNCE_CYC(DB1), .LONG_CYC(L1),
                         .DOUBLE_GAP(G1), .REPEAT_CYC(R1)) u_dut1 (
        .clock(clock), .reset(reset), .b(b), .ch_en(ch_en),
        .scurt(scurt1), .lung(lung1), .dublu(dublu1), .busy(busy1));

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got={s,l,d,busy}=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        since_rst = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) begin
                m_s1[k][c] = 0; m_s2[k][c] = 0; m_db[k][c] = 0; m_run[k][c] = 0; m_arm[k][c] = 0;
                m_rise[k][c] = -1; m_fall[k][c] = -1; m_sec[k][c] = 0;
                m_ex_s[k][c] = 0; m_ex_l[k][c] = 0; m_ex_d[k][c] = 0; m_busy[k][c] = 0;
            end
        end
    endtask

    task automatic end_press(input int k, input int c);
        m_rise[k][c] = -1;
        m_fall[k][c] = -1;
        m_sec[k][c]  = 0;
    endtask

    // One clock edge of the model; a press is described by the edge its level was first seen
    // (m_rise), the edge its release was first seen (m_fall), and whether a second press began.
    task automatic model_step();
        int s2p, dbp, held, dbc, lc, gc, rc;
        for (int k = 0; k < 2; k++) begin
            dbc = (k == 0) ? DB0 : DB1;
            lc  = (k == 0) ? L0  : L1;
            gc  = (k == 0) ? G0  : G1;
            rc  = (k == 0) ? R0  : R1;
            for (int c = 0; c < NC; c++) begin
                s2p = m_s2[k][c];
                dbp = m_db[k][c];
                m_s2[k][c] = m_s1[k][c];
                m_s1[k][c] = int'(b[c]);
                m_ex_s[k][c] = 0; m_ex_l[k][c] = 0; m_ex_d[k][c] = 0;
                if (!ch_en[c]) begin
                    m_db[k][c] = 0; m_run[k][c] = 0; m_arm[k][c] = 0;
                    end_press(k, c);
                end else begin
                    if (s2p != dbp) begin
                        m_run[k][c]++;
                        if (m_run[k][c] >= dbc) begin
                            m_db[k][c] = s2p;
                            m_run[k][c] = 0;
                        end
                    end else begin
                        m_run[k][c] = 0;
                    end
                    if (m_rise[k][c] < 0) begin
                        if (dbp != 0 && m_arm[k][c] != 0) m_rise[k][c] = t;
                        else if (dbp == 0 && s2p == 0 && since_rst >= 2) m_arm[k][c] = 1;
                    end else if (m_sec[k][c] != 0) begin
                        if (dbp == 0) begin m_ex_d[k][c] = 1; end_press(k, c); end
                    end else if (m_fall[k][c] >= 0) begin
                        if (dbp != 0) m_sec[k][c] = 1;
                        else if (t - m_fall[k][c] + 1 >= gc) begin m_ex_s[k][c] = 1; end_press(k, c); end
                    end else begin
                        held = t - m_rise[k][c] + 1;
                        if (dbp != 0) begin
                            if (held == lc || (rc > 0 && held > lc && (held - lc) % rc == 0))
                                m_ex_l[k][c] = 1;
                        end else if (t - m_rise[k][c] >= lc) begin
                            end_press(k, c);
                        end else if (gc == 0) begin
                            m_ex_s[k][c] = 1; end_press(k, c);
                        end else begin
                            m_fall[k][c] = t;
                        end
                    end
                end
                m_busy[k][c] = (m_rise[k][c] >= 0) ? 1 : 0;
            end
        end
        since_rst++;
    endtask

    function automatic logic [11:0] exp_vec(input int k);
        logic [NC-1:0] s, l, d, bz;
        for (int c = 0; c < NC; c++) begin
            s[c]  = (m_ex_s[k][c] != 0);
            l[c]  = (m_ex_l[k][c] != 0);
            d[c]  = (m_ex_d[k][c] != 0);
            bz[c] = (m_busy[k][c] != 0);
        end
        return {s, l, d, bz};
    endfunction

    task automatic check_both(input string tag);
        check({tag, "_i0"}, {scurt0, lung0, dublu0, busy0}, exp_vec(0));
        check({tag, "_i1"}, {scurt1, lung1, dublu1, busy1}, exp_vec(1));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (!reset) model_step();
        t++;
        @(negedge clock);
        check_both(tag);
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_both("rst_async");
    endtask

    function automatic int pick_len(input int level);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 1;
        if (level != 0) return (r < 6) ? int'($urandom_range(6, 14)) : int'($urandom_range(20, 50));
        return (r < 6) ? int'($urandom_range(2, 8)) : int'($urandom_range(12, 30));
    endfunction

    initial begin
        int hit;
        reset = 1'b1;
        b     = '0;
        ch_en = '1;
        model_reset();
        for (int c = 0; c < NC; c++) begin lv[c] = 0; run_left[c] = 10; en_left[c] = 0; end
        repeat (3) tick("reset");
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick("rand");
            reset = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (run_left[c] == 0) begin
                    lv[c] = (lv[c] == 0) ? 1 : 0;
                    run_left[c] = pick_len(lv[c]);
                end
                run_left[c]--;
                b[c] = (lv[c] != 0);
                if (en_left[c] > 0) begin
                    en_left[c]--;
                    ch_en[c] = (en_left[c] == 0);
                end else if ($urandom_range(0, 199) == 0) begin
                    en_left[c] = int'($urandom_range(1, 6));
                    ch_en[c] = 1'b0;
                end
            end
            if (cyc % 1000 == 999) hit_reset();
        end

        reset = 1'b0;
        ch_en = '1;
        b     = '0;
        repeat (40) tick("settle");

        // reset in the middle of a long hold, button kept pressed afterwards
        b = '1;
        repeat (15) tick("hold");
        hit_reset();
        tick("hold_rst");
        reset = 1'b0;
        repeat (60) tick("held_after_rst");
        b = '0;
        repeat (30) tick("release");

        // drop ch_en[0] exactly on the edge that would deliver the first lung[0]
        b[0] = 1'b1;
        hit = 0;
        for (int i = 0; i < 80; i++) begin
            ch_en[0] = 1'b1;
            if (hit == 0 && m_rise[0][0] >= 0 && m_fall[0][0] < 0 && m_sec[0][0] == 0 &&
                m_db[0][0] != 0 && t - m_rise[0][0] + 1 == L0) begin
                ch_en[0] = 1'b0;
                hit = 1;
            end
            tick("en_drop");
        end
        check("en_drop_reached", {11'b0, hit[0]}, 12'd1);
        ch_en = '1;
        b = '0;
        repeat (20) tick("tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
